// File: rtl/instr_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_if
// Brief    : Avalon burst-read master, redirect and instruction stream bundle.
// Revision : 1.0
// ============================================================================
interface instr_prefetch_if;
    logic [18:0] avm_addr;
    logic        avm_read;
    logic [3:0]  avm_burstcount;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    // master: the prefetcher; slave: memory plus consumer side
    modport master (
        output avm_addr, avm_read, avm_burstcount,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid,
        input  redirect, redirect_pc,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  avm_addr, avm_read, avm_burstcount,
        output avm_readdata, avm_waitrequest, avm_readdatavalid,
        output redirect, redirect_pc,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch
// Brief    : Burst instruction prefetcher with FIFO and redirect flush.
//            Optional same-cycle bypass enabled by defining PREFETCH_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module instr_prefetch #(
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  wire              clock,
    input  wire              reset_n,
    instr_prefetch_if.master bus
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  BURST_CNT = 4'(BURST_LEN);
    localparam logic [AW:0] MAX_FILL  = (AW+1)'(FIFO_DEPTH - BURST_LEN);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    beats_q, beats_d;
    logic [18:0]   fetch_q, fetch_d;
    logic [10:0]   pc_hi_q, pc_hi_d;
    logic          read_q, read_d;
    logic [18:0]   addr_q, addr_d;
    logic          drain_req_q, drain_req_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [61:0]   mem_q [FIFO_DEPTH];

    logic        w_beat_take;
    logic        w_push;
    logic        w_pop;
    logic [61:0] w_head;
    logic        w_unused_pc_bits;

    assign w_unused_pc_bits = ^bus.redirect_pc[1:0];
    assign w_beat_take = (state_q == ST_DATA) && bus.avm_readdatavalid && !bus.redirect;
    assign w_head      = mem_q[rptr_q];
    assign w_pop       = (count_q != '0) && bus.instr_ready && !bus.redirect;

`ifdef PREFETCH_BYPASS_EN
    logic w_bypass;
    // An empty FIFO lets the arriving beat go straight to the consumer.
    assign w_bypass        = w_beat_take && (count_q == '0);
    assign w_push          = w_beat_take && !(w_bypass && bus.instr_ready);
    assign bus.instr_valid = (count_q != '0) || w_bypass;
    assign bus.instr_data  = w_bypass ? bus.avm_readdata : w_head[61:30];
    assign bus.instr_pc    = w_bypass ? {pc_hi_q, fetch_q, 2'b00} : {w_head[29:0], 2'b00};
`else
    assign w_push          = w_beat_take;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr_data  = w_head[61:30];
    assign bus.instr_pc    = {w_head[29:0], 2'b00};
`endif

    assign bus.avm_read       = read_q;
    assign bus.avm_addr       = addr_q;
    assign bus.avm_burstcount = BURST_CNT;

    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        fetch_d     = fetch_q;
        pc_hi_d     = pc_hi_q;
        read_d      = read_q;
        addr_d      = addr_q;
        drain_req_d = drain_req_q;

        if (bus.redirect) begin
            fetch_d = bus.redirect_pc[20:2];
            pc_hi_d = bus.redirect_pc[31:21];
        end

        case (state_q)
            ST_IDLE: begin
                if (!bus.redirect && (count_q <= MAX_FILL)) begin
                    state_d     = ST_REQ;
                    read_d      = 1'b1;
                    addr_d      = fetch_q;
                    drain_req_d = 1'b0;
                end
            end
            ST_REQ: begin
                // A redirect seen while stalled still owes the slave a full burst.
                if (!bus.avm_waitrequest) begin
                    read_d      = 1'b0;
                    beats_d     = BURST_CNT;
                    state_d     = (bus.redirect || drain_req_q) ? ST_DRAIN : ST_DATA;
                    drain_req_d = 1'b0;
                end else if (bus.redirect) begin
                    drain_req_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (bus.avm_readdatavalid) begin
                    beats_d = beats_q - 4'd1;
                    if (!bus.redirect) begin
                        fetch_d = fetch_q + 19'd1;
                    end
                    if (beats_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end else if (bus.redirect) begin
                        state_d = ST_DRAIN;
                    end
                end else if (bus.redirect) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.avm_readdatavalid) begin
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.redirect) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) wptr_d = wptr_q + PTR_ONE;
            if (w_pop)  rptr_d = rptr_q + PTR_ONE;
            if (w_push && !w_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!w_push && w_pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            beats_q     <= 4'd0;
            fetch_q     <= RESET_PC[20:2];
            pc_hi_q     <= RESET_PC[31:21];
            read_q      <= 1'b0;
            addr_q      <= RESET_PC[20:2];
            drain_req_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            fetch_q     <= fetch_d;
            pc_hi_q     <= pc_hi_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            drain_req_q <= drain_req_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wptr_q] <= {bus.avm_readdata, pc_hi_q, fetch_q};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch
// Brief    : Directed bench with an Avalon slave and an instruction-stream model.
// Revision : 1.0
// ============================================================================
module tb_instr_prefetch;
    localparam int          BURST_LEN  = 8;
    localparam int          FIFO_DEPTH = 16;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic clock;
    logic reset_n;
    instr_prefetch_if bus();

    instr_prefetch #(
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    logic [18:0] sq[$];
    logic [31:0] bursts[$];
    logic [31:0] pop_log[$];
    logic [18:0] m_fetch;
    logic [10:0] m_hi;
    int          m_out;
    bit          m_drop, m_pend;
    bit          prev_read, prev_wait, prev_redirect;
    logic [18:0] prev_addr;
    int          cyc, beats_seen, first_rdv, first_valid;

    function automatic logic [31:0] mem_word(input logic [18:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_burst(input int i);
        return (i < bursts.size()) ? bursts[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] get_pop(input int i);
        return (i < pop_log.size()) ? pop_log[i] : 32'hFFFF_FFFF;
    endfunction

    // Avalon slave: one beat per cycle for every accepted burst, in order.
    initial begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = 32'h0;
        forever begin
            @(posedge clock); #1;
            if (sq.size() > 0) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = mem_word(sq.pop_front());
            end else begin
                bus.avm_readdatavalid = 1'b0;
            end
        end
    end

    // Model of the instruction stream plus per-cycle protocol checks.
    initial begin : monitor
        int   sz;
        bit   beat_live, beat_keep, byp;
        ent_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mq.delete();
                m_out = 0; m_drop = 0; m_pend = 0;
                m_fetch = RESET_PC[20:2];
                m_hi    = RESET_PC[31:21];
                prev_read = 0; prev_wait = 0; prev_redirect = 0;
                prev_addr = '0;
            end else begin
                cyc++;
                sz        = mq.size();
                beat_live = bus.avm_readdatavalid && (m_out > 0);
                beat_keep = beat_live && !m_drop && !bus.redirect;
                byp       = 1'b0;
`ifdef PREFETCH_BYPASS_EN
                byp = beat_keep && (sz == 0);
`endif
                chk("instr_valid", 32'(bus.instr_valid), 32'(sz > 0 || byp));
                if (sz > 0) begin
                    chk("instr_pc", bus.instr_pc, mq[0].pc);
                    chk("instr_data", bus.instr_data, mq[0].data);
                end else if (byp) begin
                    chk("bypass_pc", bus.instr_pc, {m_hi, m_fetch, 2'b00});
                    chk("bypass_data", bus.instr_data, mem_word(m_fetch));
                end
                chk("burstcount", 32'(bus.avm_burstcount), 32'(BURST_LEN));
                chk("read_while_busy", 32'(bus.avm_read && (m_out > 0)), 32'd0);
                if (bus.avm_read && !prev_read) begin
                    chk("burst_addr", 32'(bus.avm_addr), 32'(m_fetch));
                    chk("issue_after_redirect", 32'(prev_redirect), 32'd0);
                end
                if (prev_read && prev_wait) begin
                    chk("req_hold_read", 32'(bus.avm_read), 32'd1);
                    chk("req_hold_addr", 32'(bus.avm_addr), 32'(prev_addr));
                end
                if (bus.avm_readdatavalid) begin
                    beats_seen++;
                    if (first_rdv < 0) first_rdv = cyc;
                end
                if (bus.instr_valid && first_valid < 0) first_valid = cyc;

                if (sz > 0 && bus.instr_ready && !bus.redirect) begin
                    pop_log.push_back(mq[0].pc);
                    void'(mq.pop_front());
                end
                if (beat_live) begin
                    m_out--;
                    if (beat_keep) begin
                        e.pc   = {m_hi, m_fetch, 2'b00};
                        e.data = mem_word(m_fetch);
                        if (byp && bus.instr_ready) pop_log.push_back(e.pc);
                        else                        mq.push_back(e);
                        m_fetch++;
                    end
                end
                if (bus.redirect) begin
                    mq.delete();
                    m_fetch = bus.redirect_pc[20:2];
                    m_hi    = bus.redirect_pc[31:21];
                    if (m_out > 0)    m_drop = 1;
                    if (bus.avm_read) m_pend = 1;
                end
                if (bus.avm_read && !bus.avm_waitrequest) begin
                    m_out  = BURST_LEN;
                    m_drop = m_pend;
                    m_pend = 0;
                    bursts.push_back(32'(bus.avm_addr));
                    for (int i = 0; i < BURST_LEN; i++) sq.push_back(bus.avm_addr + 19'(i));
                end
                prev_read     = bus.avm_read;
                prev_wait     = bus.avm_waitrequest;
                prev_addr     = bus.avm_addr;
                prev_redirect = bus.redirect;
            end
        end
    end

    task automatic do_reset();
        int k;
        reset_n             = 1'b0;
        bus.redirect        = 1'b0;
        bus.instr_ready     = 1'b0;
        bus.avm_waitrequest = 1'b0;
        k = 0;
        while (sq.size() > 0 && k < 30) begin
            @(posedge clock);
            k++;
        end
        @(posedge clock); #1;
        chk("rst_read", 32'(bus.avm_read), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_addr", 32'(bus.avm_addr), 32'(RESET_PC[20:2]));
        bursts.delete();
        pop_log.delete();
        beats_seen = 0; first_rdv = -1; first_valid = -1;
    endtask

    task automatic wait_bursts(input int n, input int lim);
        int k = 0;
        while (bursts.size() < n && k < lim) begin
            @(posedge clock);
            k++;
        end
        #1;
        chk("wait_bursts", 32'(bursts.size() >= n), 32'd1);
    endtask

    task automatic wait_pops(input int n, input int lim);
        int k = 0;
        while (pop_log.size() < n && k < lim) begin
            @(posedge clock);
            k++;
        end
        #1;
        chk("wait_pops", 32'(pop_log.size() >= n), 32'd1);
    endtask

    task automatic wait_beats(input int n, input int lim);
        int k = 0;
        while (beats_seen < n && k < lim) begin
            @(posedge clock);
            k++;
        end
        #1;
        chk("wait_beats", 32'(beats_seen >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, p, k;
        reset_n = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0; bus.avm_waitrequest = 1'b0;
        repeat (2) @(posedge clock);

        // Straight-line fetch from reset, consumer always ready
        do_reset();
        bus.instr_ready = 1'b1;
        reset_n = 1'b1;
        wait_bursts(2, 60);
        wait_pops(8, 60);
        chk("b0_addr", get_burst(0), 32'h0);
        chk("b1_addr", get_burst(1), 32'h8);
        for (int i = 0; i < 8; i++) chk("seq_pc", get_pop(i), 32'(i * 4));
        chk("latency", 32'(first_valid - first_rdv), 32'(LAT));

        // Stalled consumer: exactly two bursts until eight words are popped
        do_reset();
        reset_n = 1'b1;
        repeat (60) @(posedge clock);
        #1;
        chk("full_bursts", 32'(bursts.size()), 32'd2);
        chk("full_valid", 32'(bus.instr_valid), 32'd1);
        bus.instr_ready = 1'b1;
        repeat (7) @(posedge clock);
        #1 bus.instr_ready = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        chk("no_third_burst", 32'(bursts.size()), 32'd2);
        bus.instr_ready = 1'b1;
        @(posedge clock);
        #1 bus.instr_ready = 1'b0;
        wait_bursts(3, 12);
        chk("third_addr", get_burst(2), 32'h10);

        // Redirect after three beats of the first burst
        do_reset();
        reset_n = 1'b1;
        wait_beats(3, 40);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100;
        @(posedge clock); #1;
        bus.redirect = 1'b0;
        chk("valid_after_redirect", 32'(bus.instr_valid), 32'd0);
        wait_bursts(2, 40);
        chk("redir_burst_addr", get_burst(1), 32'h40);
        bus.instr_ready = 1'b1;
        wait_pops(1, 40);
        chk("redir_first_pc", get_pop(0), 32'h100);

        // Stalled request with a redirect in its second cycle
        do_reset();
        bus.avm_waitrequest = 1'b1;
        bus.instr_ready = 1'b1;
        reset_n = 1'b1;
        k = 0;
        do begin
            @(posedge clock); #1;
            k++;
        end while (!bus.avm_read && k < 10);
        chk("stall_read_seen", 32'(bus.avm_read), 32'd1);
        @(posedge clock); #1;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_2000;
        @(posedge clock); #1;
        bus.redirect = 1'b0;
        chk("stall_hold_addr", 32'(bus.avm_addr), 32'h0);
        repeat (2) @(posedge clock);
        #1 bus.avm_waitrequest = 1'b0;
        wait_bursts(2, 40);
        chk("stall_b0", get_burst(0), 32'h0);
        chk("stall_b1", get_burst(1), 32'h800);
        wait_pops(1, 40);
        chk("stall_first_pc", get_pop(0), 32'h2000);

        // Fetch address wrap inside one burst, redirect in IDLE at release
        do_reset();
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h001F_FFF0;
        reset_n = 1'b1;
        @(posedge clock); #1;
        bus.redirect = 1'b0;
        wait_pops(8, 60);
        chk("wrap_burst", get_burst(0), 32'h7FFFC);
        chk("wrap_pc3", get_pop(3), 32'h001F_FFFC);
        chk("wrap_pc4", get_pop(4), 32'h0);
        chk("wrap_pc7", get_pop(7), 32'hC);

        // Reset in the middle of a burst; stray beats must be ignored
        do_reset();
        bus.instr_ready = 1'b1;
        reset_n = 1'b1;
        wait_beats(3, 40);
        n = bursts.size();
        p = pop_log.size();
        bus.avm_waitrequest = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("midrst_read", 32'(bus.avm_read), 32'd0);
        chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        k = 0;
        while (sq.size() > 0 && k < 20) begin
            @(posedge clock);
            k++;
        end
        @(posedge clock); #1;
        bus.avm_waitrequest = 1'b0;
        wait_bursts(n + 1, 40);
        chk("midrst_burst", get_burst(n), 32'(RESET_PC[20:2]));
        wait_pops(p + 1, 40);
        chk("midrst_first_pc", get_pop(p), RESET_PC);

        // Redirect together with a pop: redirect wins, nothing consumed
        do_reset();
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0400;
        @(posedge clock); #1;
        bus.redirect = 1'b0;
        chk("prio_valid", 32'(bus.instr_valid), 32'd0);
        chk("prio_no_pop", 32'(pop_log.size()), 32'd0);
        wait_pops(1, 40);
        chk("prio_burst", get_burst(2), 32'h100);
        chk("prio_first_pc", get_pop(0), 32'h400);

        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL provide parameter BURST_LEN, default 8, meaning words per Avalon burst read; legal values 1..8.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 16, meaning instruction buffer entries; power of 2, at least 2*BURST_LEN.
REQ-003 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the byte address fetched after reset.
REQ-004 Ports, one clock, reset asynchronous active-low:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- avm_addr  out  19  word address of the burst (pc[20:2]).
- avm_read  out  1  burst read request.
- avm_burstcount  out  4  constant BURST_LEN.
- avm_readdata  in  32  returned word.
- avm_waitrequest  in  1  slave stall; request held while high.
- avm_readdatavalid  in  1  avm_readdata valid this cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new byte PC; bits [1:0] ignored.
- instr_valid  out  1  instr_data/instr_pc valid.
- instr_ready  in  1  consumer accepts when valid and ready are both high.
- instr_data  out  32  instruction word.
- instr_pc  out  32  byte address of instr_data; bits [1:0] always 00.

Function
REQ-005 SHALL implement FSM with states IDLE, REQ, DATA and DRAIN, with exactly one burst outstanding at a time.
REQ-006 IDLE->REQ SHALL occur when free FIFO slots >= BURST_LEN and redirect is low; avm_read and avm_addr are registered and asserted in REQ.
REQ-007 In REQ, avm_read, avm_addr and avm_burstcount SHALL hold stable until a cycle with avm_waitrequest low; that cycle completes acceptance and moves to DATA, with the beat counter set to BURST_LEN.
REQ-008 In DATA, each avm_readdatavalid SHALL write the word and its PC into the FIFO, decrement the beat counter and advance the fetch address by 1 word; last beat -> IDLE.
REQ-009 The fetch address SHALL be 19 bits and wrap 0x7FFFF->0x00000; instr_pc[31:21] SHALL hold the upper bits of the last redirect or RESET_PC.
REQ-010 redirect SHALL empty the FIFO in the same cycle, force instr_valid low on the next cycle, and load the fetch address from redirect_pc[20:2].
REQ-011 redirect in REQ SHALL keep the request asserted until accepted, then enter DRAIN with count BURST_LEN.
REQ-012 redirect in DATA SHALL enter DRAIN with the remaining beat count; a beat in the redirect cycle is discarded and counted.
REQ-013 DRAIN SHALL discard all beats; the last beat -> IDLE, and the new burst is issued no earlier than the following cycle.
REQ-014 redirect in IDLE SHALL stay in IDLE and SHALL block burst issue in that cycle.
REQ-015 redirect together with pop SHALL give priority to redirect; no word is consumed.
REQ-016 Simultaneous FIFO push and pop SHALL keep the occupancy count unchanged; overflow is impossible by REQ-006.
REQ-017 Without bypass, a word SHALL appear on instr_valid no earlier than 1 cycle after its avm_readdatavalid.

Reset
REQ-018 reset_n low SHALL asynchronously set: state IDLE, avm_read 0, avm_addr RESET_PC[20:2], FIFO empty, instr_valid 0, beat counter 0, fetch address RESET_PC.
REQ-019 Reset during REQ/DATA/DRAIN SHALL abandon the burst; stray beats after reset SHALL be ignored while in IDLE.

Configuration
REQ-020 With PREFETCH_BYPASS_EN defined, a beat arriving in DATA with the FIFO empty SHALL drive instr_valid/instr_data/instr_pc combinationally in the same cycle, and is not written if accepted with instr_ready; without the macro, REQ-017 latency applies and no combinational path exists from avm_* to instr_*.

Verification
REQ-021 Reset, zero waitrequest, 1-cycle readdatavalid -> burst at avm_addr 0x00000 count 8; instr_pc 0x0,0x4..0x1C in order; second burst at 0x00008.
REQ-022 instr_ready held low -> exactly two bursts issued (16 words), no third request until at least 8 words are popped.
REQ-023 redirect to 0x0000_0100 after 3 of 8 beats -> 5 beats discarded; next request avm_addr 0x00040; first instr_pc 0x100.
REQ-024 avm_waitrequest high 5 cycles with redirect in cycle 2 -> request held stable, 8 beats drained, new burst at redirect address.
REQ-025 Fetch address 0x7FFFC with BURST_LEN 8 -> PCs wrap to 0x000000 after word 0x1FFFFC within a single burst.
REQ-026 With PREFETCH_BYPASS_EN, FIFO empty, instr_ready high -> instr_valid in the same cycle as avm_readdatavalid; without the macro -> instr_valid one cycle later.
